alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 The block SHALL have a parameter REPEAT_CYCLES, default 50_000_000, meaning clock cycles between auto-repeat increments while a tick button is held.
REQ-002 The block SHALL have a parameter TONE_DIV, default 50_000, meaning clock cycles per half-period of the buzzer tone.
REQ-003 The block SHALL have a parameter RING_SECONDS, default 60, meaning the ringing timeout in tick_1Hz pulses.
REQ-004 The block SHALL have port clk_100MHz, input, 1 bit, the single clock for all logic.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous and active-high.
REQ-006 The block SHALL have port tick_1Hz, input, 1 bit, a one-cycle pulse once per second from the timekeeper.
REQ-007 The block SHALL have port cur_hr, input, 5 bits, the current hour in binary (0-23).
REQ-008 The block SHALL have port cur_min, input, 6 bits, the current minute in binary (0-59).
REQ-009 The block SHALL have port cur_sec, input, 6 bits, the current second in binary (0-59).
REQ-010 The block SHALL have port set_alarm, input, 1 bit, a level that selects alarm-set mode.
REQ-011 The block SHALL have port tick_hr, input, 1 bit, a debounced level that increments the hour.
REQ-012 The block SHALL have port tick_min, input, 1 bit, a debounced level that increments the minute.
REQ-013 The block SHALL have port alarm_en, input, 1 bit, a level that arms the alarm.
REQ-014 The block SHALL have port alarm_hr, output, 5 bits, the stored alarm hour, for the display.
REQ-015 The block SHALL have port alarm_min, output, 6 bits, the stored alarm minute, for the display.
REQ-016 The block SHALL have port ringing, output, 1 bit, high while the FSM is in RINGING.
REQ-017 The block SHALL have port buzzer, output, 1 bit, the gated tone output.

Function
REQ-018 Tick edge handling: when set_alarm=1 and the rising edge of tick_min is seen (previous sample 0, current sample 1), alarm_min SHALL increment on the next clock edge.
REQ-019 Auto-repeat: while set_alarm and tick_min stay high, alarm_min SHALL increment again every REPEAT_CYCLES cycles; the repeat counter SHALL clear when tick_min falls.
REQ-020 Hour ticks: tick_hr SHALL behave identically to tick_min but act on alarm_hr, using an independent repeat counter.
REQ-021 Simultaneous ticks: tick_hr and tick_min asserted together SHALL both take effect in the same cycle.
REQ-022 Wrap: minute 59 SHALL wrap to 0 with no carry into the hour; hour 23 SHALL wrap to 0.
REQ-023 Set mode off: tick inputs SHALL be ignored while set_alarm=0.
REQ-024 The FSM SHALL have exactly three states: IDLE, RINGING and DONE.
REQ-025 IDLE->RINGING SHALL occur when alarm_en=1, set_alarm=0, cur_hr==alarm_hr, cur_min==alarm_min and cur_sec==0, all in the same cycle.
REQ-026 On entering RINGING, the second counter SHALL load 0, the gate SHALL load 1 and the tone SHALL load 1.
REQ-027 RINGING->DONE SHALL occur on the tick_1Hz pulse that brings the second counter to RING_SECONDS.
REQ-028 RINGING->IDLE SHALL occur on alarm_en=0 or set_alarm=1; this exit SHALL take priority over the timeout.
REQ-029 DONE->IDLE SHALL occur when cur_min!=alarm_min, cur_hr!=alarm_hr or alarm_en=0, so the alarm cannot retrigger within the same minute.
REQ-030 ringing SHALL be registered and SHALL equal (state==RINGING).
REQ-031 Tone: in RINGING, the tone bit SHALL toggle every TONE_DIV cycles.
REQ-032 Gate: in RINGING, the gate SHALL toggle on each tick_1Hz pulse, giving 1 s on and 1 s off.
REQ-033 buzzer SHALL be registered, equal to tone AND gate while in RINGING, and 0 in every other state.
REQ-034 Buzzer shutoff: buzzer SHALL be 0 on the first clock edge after the FSM leaves RINGING.
REQ-035 Alarm editing: changes to alarm_hr/alarm_min while in DONE SHALL be permitted and SHALL take effect immediately.
REQ-036 Width: all counters SHALL be sized to hold their parameter value without overflow.

Reset
REQ-037 On reset=1 at a clock edge, alarm_hr SHALL be 0 and alarm_min SHALL be 0.
REQ-038 On reset=1 at a clock edge, the state SHALL be IDLE, and ringing and buzzer SHALL be 0.
REQ-039 On reset=1 at a clock edge, all counters, the gate, the tone bit and the edge-detect registers SHALL clear.
REQ-040 Reset SHALL take priority over every other input, including reset asserted mid-RINGING (buzzer 0 on the next edge).

Verification (REPEAT_CYCLES=4, TONE_DIV=2, RING_SECONDS=3)
REQ-041 The bench SHALL cover: set_alarm=1 with tick_min held 14 cycles -> alarm_min increments 1 cycle after the edge, then every 4 cycles, total 4; tick_hr held 14 cycles -> alarm_hr=4.
REQ-042 The bench SHALL cover: alarm_min=59 and alarm_hr=23, one tick_min pulse and one tick_hr pulse -> alarm_min=0, alarm_hr=0, no carry.
REQ-043 The bench SHALL cover: alarm 04:04, alarm_en=1, cur 04:04:00 -> ringing=1 next cycle; buzzer toggles every 2 cycles; silent during odd seconds; after 3 tick_1Hz pulses state=DONE and buzzer=0.
REQ-044 The bench SHALL cover: in DONE with cur_min still 04 -> no retrigger; cur_min becomes 05 -> state=IDLE.
REQ-045 The bench SHALL cover: while ringing, drop alarm_en -> ringing=0 and buzzer=0 on the next edge.
REQ-046 The bench SHALL cover: while ringing, assert reset -> all outputs 0 and alarm_hr/alarm_min=0 on the next edge.

Source files
------------

// File: rtl/alarm_ctrl.sv
// alarm_ctrl -- alarm-time storage, set-mode button handling and ringing FSM.
//
// Ports:
//   clk_100MHz  in   single clock for all logic
//   reset       in   synchronous, active-high
//   tick_1Hz    in   one-cycle pulse per second from the timekeeper
//   cur_hr      in   [4:0] current hour (0-23)
//   cur_min     in   [5:0] current minute (0-59)
//   cur_sec     in   [5:0] current second (0-59)
//   set_alarm   in   level, selects alarm-set mode
//   tick_hr     in   debounced level, increments alarm hour (edge + auto-repeat)
//   tick_min    in   debounced level, increments alarm minute (edge + auto-repeat)
//   alarm_en    in   level, arms the alarm
//   alarm_hr    out  [4:0] stored alarm hour
//   alarm_min   out  [5:0] stored alarm minute
//   ringing     out  registered, high while in RINGING
//   buzzer      out  registered, tone AND gate while in RINGING, else 0
`timescale 1ns/1ps
module alarm_ctrl #(
  parameter int unsigned REPEAT_CYCLES = 50_000_000,
  parameter int unsigned TONE_DIV      = 50_000,
  parameter int unsigned RING_SECONDS  = 60
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       set_alarm,
  input  logic       tick_hr,
  input  logic       tick_min,
  input  logic       alarm_en,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_min,
  output logic       ringing,
  output logic       buzzer
);

  localparam int unsigned RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam int unsigned TW = (TONE_DIV > 1)      ? $clog2(TONE_DIV + 1)      : 1;
  localparam int unsigned SW = (RING_SECONDS > 1)  ? $clog2(RING_SECONDS + 1)  : 1;

  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
  localparam logic [SW-1:0] SEC_LAST  = SW'(RING_SECONDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    DONE    = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Alarm-time setting
  // ---------------------------------------------------------------------
  logic [4:0]    r_alarm_hr;
  logic [5:0]    r_alarm_min;
  logic          r_tmin_d, r_thr_d;
  logic [RW-1:0] r_rep_min, r_rep_hr;

  logic          w_min_step, w_hr_step;
  logic [RW-1:0] w_rep_min_nxt, w_rep_hr_nxt;

  // A fresh rising edge steps immediately and restarts the repeat count;
  // a held button steps again each time the count reaches REPEAT_CYCLES-1.
  always_comb begin
    w_min_step    = 1'b0;
    w_rep_min_nxt = '0;
    if (set_alarm && tick_min) begin
      if (!r_tmin_d) begin
        w_min_step = 1'b1;
      end else if (r_rep_min == REP_LAST) begin
        w_min_step = 1'b1;
      end else begin
        w_rep_min_nxt = r_rep_min + 1'b1;
      end
    end
  end

  always_comb begin
    w_hr_step    = 1'b0;
    w_rep_hr_nxt = '0;
    if (set_alarm && tick_hr) begin
      if (!r_thr_d) begin
        w_hr_step = 1'b1;
      end else if (r_rep_hr == REP_LAST) begin
        w_hr_step = 1'b1;
      end else begin
        w_rep_hr_nxt = r_rep_hr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_alarm_hr  <= '0;
      r_alarm_min <= '0;
      r_tmin_d    <= 1'b0;
      r_thr_d     <= 1'b0;
      r_rep_min   <= '0;
      r_rep_hr    <= '0;
    end else begin
      r_tmin_d  <= tick_min;
      r_thr_d   <= tick_hr;
      r_rep_min <= w_rep_min_nxt;
      r_rep_hr  <= w_rep_hr_nxt;
      if (w_min_step) begin
        r_alarm_min <= (r_alarm_min == 6'd59) ? '0 : r_alarm_min + 6'd1;
      end
      if (w_hr_step) begin
        r_alarm_hr <= (r_alarm_hr == 5'd23) ? '0 : r_alarm_hr + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Ringing FSM
  // ---------------------------------------------------------------------
  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_sec, w_sec_nxt;
  logic [TW-1:0] r_tone_cnt, w_tone_cnt_nxt;
  logic          r_tone, w_tone_nxt;
  logic          r_gate, w_gate_nxt;
  logic          r_ringing, r_buzzer;
  logic          w_match;

  assign w_match = alarm_en && !set_alarm &&
                   (cur_hr == r_alarm_hr) && (cur_min == r_alarm_min) &&
                   (cur_sec == 6'd0);

  always_comb begin
    w_state_nxt    = r_state;
    w_sec_nxt      = r_sec;
    w_tone_cnt_nxt = r_tone_cnt;
    w_tone_nxt     = r_tone;
    w_gate_nxt     = r_gate;
    case (r_state)
      IDLE: begin
        if (w_match) begin
          w_state_nxt    = RINGING;
          w_sec_nxt      = '0;
          w_tone_cnt_nxt = '0;
          w_tone_nxt     = 1'b1;
          w_gate_nxt     = 1'b1;
        end
      end
      RINGING: begin
        // User cancel wins over the timeout on the same cycle.
        if (!alarm_en || set_alarm) begin
          w_state_nxt = IDLE;
        end else if (tick_1Hz && (r_sec == SEC_LAST)) begin
          w_state_nxt = DONE;
        end else begin
          if (r_tone_cnt == TONE_LAST) begin
            w_tone_cnt_nxt = '0;
            w_tone_nxt     = ~r_tone;
          end else begin
            w_tone_cnt_nxt = r_tone_cnt + 1'b1;
          end
          if (tick_1Hz) begin
            w_sec_nxt  = r_sec + 1'b1;
            w_gate_nxt = ~r_gate;
          end
        end
      end
      DONE: begin
        // Hold here until the matching minute has passed so it cannot retrigger.
        if ((cur_min != r_alarm_min) || (cur_hr != r_alarm_hr) || !alarm_en) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt != RINGING) begin
      w_sec_nxt      = '0;
      w_tone_cnt_nxt = '0;
      w_tone_nxt     = 1'b0;
      w_gate_nxt     = 1'b0;
    end
  end

  // Outputs are registered from next-state values so they track the state
  // register exactly, silencing the buzzer on the edge that leaves RINGING.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sec      <= '0;
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
      r_gate     <= 1'b0;
      r_ringing  <= 1'b0;
      r_buzzer   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sec      <= w_sec_nxt;
      r_tone_cnt <= w_tone_cnt_nxt;
      r_tone     <= w_tone_nxt;
      r_gate     <= w_gate_nxt;
      r_ringing  <= (w_state_nxt == RINGING);
      r_buzzer   <= (w_state_nxt == RINGING) && w_tone_nxt && w_gate_nxt;
    end
  end

  assign alarm_hr  = r_alarm_hr;
  assign alarm_min = r_alarm_min;
  assign ringing   = r_ringing;
  assign buzzer    = r_buzzer;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl -- scoreboard bench for alarm_ctrl with small parameters
// (REPEAT_CYCLES=4, TONE_DIV=2, RING_SECONDS=3). Stimulus queues the expected
// outputs for the cycle after each drive; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_alarm_ctrl;

  logic       clk_100MHz;
  logic       reset;
  logic       tick_1Hz;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic       set_alarm;
  logic       tick_hr;
  logic       tick_min;
  logic       alarm_en;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       ringing;
  logic       buzzer;

  alarm_ctrl #(
    .REPEAT_CYCLES(4),
    .TONE_DIV(2),
    .RING_SECONDS(3)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .tick_1Hz(tick_1Hz),
    .cur_hr(cur_hr),
    .cur_min(cur_min),
    .cur_sec(cur_sec),
    .set_alarm(set_alarm),
    .tick_hr(tick_hr),
    .tick_min(tick_min),
    .alarm_en(alarm_en),
    .alarm_hr(alarm_hr),
    .alarm_min(alarm_min),
    .ringing(ringing),
    .buzzer(buzzer)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  int unsigned cyc = 0;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  typedef struct {
    int unsigned tgt;
    string       nm;
    logic [4:0]  h;
    logic [5:0]  m;
    logic        r;
    logic        b;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Ringing sequence R0..R14, tick_1Hz at R6, R10, R14 (bit k = step k).
  logic [14:0] ring_tbl = 15'h3FFF;
  logic [14:0] buz_tbl  = 15'h3033;

  always @(negedge clk_100MHz) begin
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (alarm_hr !== e.h || alarm_min !== e.m || ringing !== e.r || buzzer !== e.b) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got hr=%0d min=%0d ringing=%b buzzer=%b, want hr=%0d min=%0d ringing=%b buzzer=%b",
                 e.nm, cyc, alarm_hr, alarm_min, ringing, buzzer, e.h, e.m, e.r, e.b);
      end
    end
  end

  // Inputs are already set; queue what the outputs must be after the next
  // posedge, then move on to the following negedge.
  task automatic step(input string nm, input logic [4:0] h, input logic [5:0] m,
                      input logic r, input logic b);
    exp_t x;
    x.tgt = cyc + 1;
    x.nm  = nm;
    x.h   = h;
    x.m   = m;
    x.r   = r;
    x.b   = b;
    sb.push_back(x);
    @(negedge clk_100MHz);
  endtask

  initial begin
    reset     = 1'b1;
    tick_1Hz  = 1'b0;
    cur_hr    = '0;
    cur_min   = '0;
    cur_sec   = '0;
    set_alarm = 1'b0;
    tick_hr   = 1'b0;
    tick_min  = 1'b0;
    alarm_en  = 1'b0;
    @(negedge clk_100MHz);

    step("reset", 5'd0, 6'd0, 1'b0, 1'b0);
    step("reset_hold", 5'd0, 6'd0, 1'b0, 1'b0);
    reset     = 1'b0;
    set_alarm = 1'b1;
    step("idle", 5'd0, 6'd0, 1'b0, 1'b0);

    // Held buttons: step on edge, then every 4 cycles -> 4 steps in 14 cycles.
    tick_min = 1'b1;
    for (int k = 0; k < 14; k++) step("min_repeat", 5'd0, 6'(1 + k / 4), 1'b0, 1'b0);
    tick_min = 1'b0;
    step("min_release", 5'd0, 6'd4, 1'b0, 1'b0);
    tick_hr = 1'b1;
    for (int k = 0; k < 14; k++) step("hr_repeat", 5'(1 + k / 4), 6'd4, 1'b0, 1'b0);
    tick_hr = 1'b0;
    step("hr_release", 5'd4, 6'd4, 1'b0, 1'b0);

    // Simultaneous pulses: both fields step in the same cycle.
    for (int i = 0; i < 19; i++) begin
      tick_hr = 1'b1; tick_min = 1'b1;
      step("both_tick", 5'(5 + i), 6'(5 + i), 1'b0, 1'b0);
      tick_hr = 1'b0; tick_min = 1'b0;
      step("both_low", 5'(5 + i), 6'(5 + i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 36; i++) begin
      tick_min = 1'b1;
      step("min_tick", 5'd23, 6'(24 + i), 1'b0, 1'b0);
      tick_min = 1'b0;
      step("min_low", 5'd23, 6'(24 + i), 1'b0, 1'b0);
    end

    // Wrap without carry.
    tick_min = 1'b1;
    step("min_wrap", 5'd23, 6'd0, 1'b0, 1'b0);
    tick_min = 1'b0;
    step("min_wrap_low", 5'd23, 6'd0, 1'b0, 1'b0);
    tick_hr = 1'b1;
    step("hr_wrap", 5'd0, 6'd0, 1'b0, 1'b0);
    tick_hr = 1'b0;
    step("hr_wrap_low", 5'd0, 6'd0, 1'b0, 1'b0);

    // Ticks ignored outside set mode.
    set_alarm = 1'b0;
    tick_hr = 1'b1; tick_min = 1'b1;
    step("set_off_ignored", 5'd0, 6'd0, 1'b0, 1'b0);
    tick_hr = 1'b0; tick_min = 1'b0;
    step("set_off_low", 5'd0, 6'd0, 1'b0, 1'b0);

    // Program 04:04.
    set_alarm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_hr = 1'b1; tick_min = 1'b1;
      step("set_0404", 5'(i + 1), 6'(i + 1), 1'b0, 1'b0);
      tick_hr = 1'b0; tick_min = 1'b0;
      step("set_0404_low", 5'(i + 1), 6'(i + 1), 1'b0, 1'b0);
    end
    set_alarm = 1'b0;
    step("set_done", 5'd4, 6'd4, 1'b0, 1'b0);

    // Ring: tone 2 on / 2 off, gate off for the second second, DONE on 3rd tick.
    cur_hr   = 5'd4;
    cur_min  = 6'd4;
    cur_sec  = 6'd0;
    alarm_en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick_1Hz = (k == 6 || k == 10 || k == 14);
      step("ring_seq", 5'd4, 6'd4, ring_tbl[k], buz_tbl[k]);
    end
    tick_1Hz = 1'b0;

    // DONE holds through the matching minute even with cur_sec still 0.
    for (int k = 0; k < 3; k++) step("done_no_retrigger", 5'd4, 6'd4, 1'b0, 1'b0);
    cur_min = 6'd5;
    step("done_to_idle", 5'd4, 6'd4, 1'b0, 1'b0);
    cur_min = 6'd4;
    step("retrigger_from_idle", 5'd4, 6'd4, 1'b1, 1'b1);
    step("ring_hold", 5'd4, 6'd4, 1'b1, 1'b1);

    // Cancel by dropping alarm_en.
    alarm_en = 1'b0;
    step("en_drop", 5'd4, 6'd4, 1'b0, 1'b0);
    step("en_off", 5'd4, 6'd4, 1'b0, 1'b0);
    alarm_en = 1'b1;
    step("rearm", 5'd4, 6'd4, 1'b1, 1'b1);

    // Reset mid-ring.
    reset = 1'b1;
    step("reset_mid_ring", 5'd0, 6'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step("post_reset", 5'd0, 6'd0, 1'b0, 1'b0);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk_100MHz);
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations still pending, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
